remote_player_rx: RTL and testbench
===================================

# remote_player_rx

Board 1 receive stage for the second player's controls arriving over GPIO from Board 2, plus the score register whose value is driven back across GPIO to Board 2's score display. The block synchronises the raw remote move/colour/play lines, debounces them, and presents clean paddle-direction levels, a one-cycle play pulse, and a colour latched only while no game is running. It also keeps player 2's saturating score counter and drives it onto the GPIO score lines.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced line changes (5 ms at 50 MHz); minimum 2
- CNT_WIDTH, 18, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES
- MAX_SCORE, 9, score saturation value (≤ 15)

- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- gpio_move  input  2  remote keys, asynchronous, active-low; [1]=up, [0]=down
- gpio_colour  input  3  remote switches, asynchronous, active-high
- gpio_play  input  1  remote play key, asynchronous, active-low
- game_active  input  1  high while a rally/game is in progress (from game FSM)
- score_inc  input  1  one-cycle pulse: player 2 scored
- score_clr  input  1  one-cycle pulse: clear score (new match)
- move_up  output  1  debounced, active-high, paddle up request
- move_down  output  1  debounced, active-high, paddle down request
- colour_out  output  3  latched paddle colour
- play_pulse  output  1  one-cycle pulse per debounced play press
- gpio_score  output  4  player 2 score, registered, to GPIO

## Operation
- Synchroniser: each of the 6 GPIO bits passes through 2 flops. Reset loads idle levels: move/play flops 1, colour flops 0.
- Debouncer, per bit, independent: holds debounced state D and counter C. If sync output equals D, C←0. Otherwise C←C+1; when C reaches DEBOUNCE_CYCLES−1 while still differing, D←sync output and C←0 on the same edge.
- Reset: D idle (move/play 1, colour 0), all C 0.
- move_up = ~D_up & D_down; move_down = ~D_down & D_up. Both keys pressed, or neither: both outputs 0.
- play_pulse: registered, high for exactly one cycle on the edge after D_play goes 1→0. A held key gives no further pulses; release gives none.
- colour_out: register loads debounced colour on every cycle game_active=0 and holds while game_active=1. A switch change during play takes effect on the first cycle after game_active falls.
- Score counter S (4 bits) drives gpio_score directly:
  - score_clr=1: S←0. Clear has priority over increment.
  - else score_inc=1 and S<MAX_SCORE: S←S+1.
  - S=MAX_SCORE: S holds (saturates; no wrap).
- Reset values: move_up 0, move_down 0, play_pulse 0, colour_out 0, gpio_score 0.

## Timing
- Input latency: an input change that is stable from the first clock edge that samples it appears on the debounced output after exactly DEBOUNCE_CYCLES+2 edges, counted from that sampling edge.
  - move_up/move_down follow combinationally from D.
  - play_pulse appears one edge after D_play changes.
- Glitch rejection: any excursion lasting fewer than DEBOUNCE_CYCLES cycles at the synchroniser output produces no change; C returns to 0.
- Bouncing: the counter restarts on each bounce. Output changes only after the last bounce plus DEBOUNCE_CYCLES.
- Score: gpio_score updates on the edge after score_inc/score_clr. score_inc and score_clr in the same cycle give S=0.
- Reset asserted mid-debounce or mid-game: every output returns to its reset value on the next edge. No pulse is emitted on reset release, even if a key is held; a held play key must be released and re-pressed.

## Test plan
Bench parameter: DEBOUNCE_CYCLES=4.

- Reset, all lines idle -> move_up=0, move_down=0, play_pulse=0, colour_out=0, gpio_score=0.
- gpio_move=2'b01 (up pressed) held 20 cycles -> move_up rises exactly 6 edges after first sampling edge; move_down=0. Then gpio_move=2'b00 -> both 0 after 6 edges.
- gpio_play low-glitch of 3 cycles -> no play_pulse. Then held low 20 cycles -> exactly one play_pulse, 7 edges after first sampling edge.
- game_active=0, gpio_colour=3'b101 -> colour_out=101. Set game_active=1, gpio_colour=3'b010 -> colour_out stays 101. Drop game_active -> colour_out=010 one edge after debounced value is valid.
- 12 score_inc pulses -> gpio_score counts 1..9 and holds at 9. Then score_inc and score_clr in the same cycle -> gpio_score=0.
- Assert reset while up held with gpio_score=5 -> all outputs 0 next edge. Release reset with up still held -> move_up reasserts after 6 edges; play_pulse stays 0.

Source files
------------

// File: rtl/remote_player_rx_if.sv
// Remote player 2 GPIO receive bundle: raw remote lines in,
// clean paddle controls and score out.
interface remote_player_rx_if;
  logic [1:0] gpio_move;
  logic [2:0] gpio_colour;
  logic       gpio_play;
  logic       game_active;
  logic       score_inc;
  logic       score_clr;
  logic       move_up;
  logic       move_down;
  logic [2:0] colour_out;
  logic       play_pulse;
  logic [3:0] gpio_score;

  modport master (
    output gpio_move, gpio_colour, gpio_play,
    output game_active, score_inc, score_clr,
    input  move_up, move_down, colour_out,
    input  play_pulse, gpio_score
  );

  modport slave (
    input  gpio_move, gpio_colour, gpio_play,
    input  game_active, score_inc, score_clr,
    output move_up, move_down, colour_out,
    output play_pulse, gpio_score
  );
endinterface

// File: rtl/remote_player_rx.sv
// Player 2 remote control receiver: sync, debounce, play pulse,
// colour latch and saturating score register.
module remote_player_rx #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18,
  parameter int MAX_SCORE       = 9
) (
  input  logic              clock,
  input  logic              reset,
  remote_player_rx_if.slave bus
);

  // Bit order: up, down, play, colour[2:0]
  localparam logic [5:0] IDLE = 6'b111_000;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] SCORE_MAX = 4'(MAX_SCORE);

  logic [5:0]           raw;
  logic [5:0]           s1;
  logic [5:0]           s2;
  logic [5:0]           d;
  logic [CNT_WIDTH-1:0] cnt [6];

  logic       play_q;
  logic [1:0] hold_cnt;
  logic       armed;
  logic       pulse_q;
  logic [2:0] colour_q;
  logic [3:0] score;

  assign raw = {bus.gpio_move, bus.gpio_play, bus.gpio_colour};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 6; i++) begin
      if (reset) begin
        d[i]   <= IDLE[i];
        cnt[i] <= '0;
      end else if (s2[i] == d[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        d[i]   <= s2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // A key held through reset must be seen released before it can fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      play_q   <= 1'b1;
      hold_cnt <= '0;
      armed    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      play_q   <= d[3];
      pulse_q  <= armed & play_q & ~d[3];
      armed    <= armed | (hold_cnt == 2'd3);
      if (!s2[3])
        hold_cnt <= '0;
      else if (hold_cnt != 2'd3)
        hold_cnt <= hold_cnt + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      colour_q <= '0;
    else if (!bus.game_active)
      colour_q <= d[2:0];
  end

  always_ff @(posedge clock) begin
    if (reset || bus.score_clr)
      score <= '0;
    else if (bus.score_inc && score < SCORE_MAX)
      score <= score + 4'd1;
  end

  assign bus.move_up    = ~d[5] & d[4];
  assign bus.move_down  = ~d[4] & d[5];
  assign bus.play_pulse = pulse_q;
  assign bus.colour_out = colour_q;
  assign bus.gpio_score = score;

endmodule

// File: tb/tb_remote_player_rx.sv
// Directed bench for remote_player_rx with a short debounce window.
module tb_remote_player_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  remote_player_rx_if bus ();

  remote_player_rx #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3),
    .MAX_SCORE(9)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.gpio_move   = 2'b11;
    bus.gpio_colour = 3'b000;
    bus.gpio_play   = 1'b1;
    bus.game_active = 1'b0;
    bus.score_inc   = 1'b0;
    bus.score_clr   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.move_up !== 1'b0)
      $display("FAIL rst_up got %0b exp 0", bus.move_up);
    else pass_cnt++;
    total++;
    if (bus.move_down !== 1'b0)
      $display("FAIL rst_down got %0b exp 0", bus.move_down);
    else pass_cnt++;
    total++;
    if (bus.play_pulse !== 1'b0)
      $display("FAIL rst_play got %0b exp 0", bus.play_pulse);
    else pass_cnt++;
    total++;
    if (bus.colour_out !== 3'b000)
      $display("FAIL rst_colour got %0b exp 000", bus.colour_out);
    else pass_cnt++;
    total++;
    if (bus.gpio_score !== 4'd0)
      $display("FAIL rst_score got %0d exp 0", bus.gpio_score);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_move();
    bus.gpio_move = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 4 && k <= 7) begin
        total++;
        if (bus.move_up !== (k >= 6))
          $display("FAIL up_rise k=%0d got %0b exp %0b",
                   k, bus.move_up, (k >= 6));
        else pass_cnt++;
      end
      if (k == 20) begin
        total++;
        if (bus.move_down !== 1'b0)
          $display("FAIL up_down got %0b exp 0", bus.move_down);
        else pass_cnt++;
      end
    end
    bus.gpio_move = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5 || k == 6) begin
        total++;
        if (bus.move_up !== (k == 5))
          $display("FAIL both_up k=%0d got %0b exp %0b",
                   k, bus.move_up, (k == 5));
        else pass_cnt++;
      end
      if (k == 8) begin
        total++;
        if (bus.move_down !== 1'b0)
          $display("FAIL both_down got %0b exp 0", bus.move_down);
        else pass_cnt++;
      end
    end
    bus.gpio_move = 2'b11;
    repeat (10) tick();
  endtask

  task automatic test_play();
    int pulses;
    int at;
    pulses = 0;
    bus.gpio_play = 1'b0;
    repeat (3) tick();
    bus.gpio_play = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.play_pulse === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0)
      $display("FAIL glitch_pulses got %0d exp 0", pulses);
    else pass_cnt++;
    pulses = 0;
    at = 0;
    bus.gpio_play = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.play_pulse === 1'b1) begin
        pulses++;
        at = k;
      end
    end
    total++;
    if (pulses !== 1)
      $display("FAIL press_pulses got %0d exp 1", pulses);
    else pass_cnt++;
    total++;
    if (at !== 7)
      $display("FAIL press_edge got %0d exp 7", at);
    else pass_cnt++;
    pulses = 0;
    bus.gpio_play = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.play_pulse === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0)
      $display("FAIL release_pulses got %0d exp 0", pulses);
    else pass_cnt++;
  endtask

  task automatic test_colour();
    bus.game_active = 1'b0;
    bus.gpio_colour = 3'b101;
    repeat (10) tick();
    total++;
    if (bus.colour_out !== 3'b101)
      $display("FAIL colour_idle got %0b exp 101", bus.colour_out);
    else pass_cnt++;
    bus.game_active = 1'b1;
    bus.gpio_colour = 3'b010;
    repeat (10) tick();
    total++;
    if (bus.colour_out !== 3'b101)
      $display("FAIL colour_hold got %0b exp 101", bus.colour_out);
    else pass_cnt++;
    bus.game_active = 1'b0;
    tick();
    total++;
    if (bus.colour_out !== 3'b010)
      $display("FAIL colour_load got %0b exp 010", bus.colour_out);
    else pass_cnt++;
  endtask

  task automatic test_score();
    logic [3:0] exp;
    for (int i = 1; i <= 12; i++) begin
      bus.score_inc = 1'b1;
      tick();
      bus.score_inc = 1'b0;
      exp = (i > 9) ? 4'd9 : 4'(i);
      total++;
      if (bus.gpio_score !== exp)
        $display("FAIL score_inc i=%0d got %0d exp %0d",
                 i, bus.gpio_score, exp);
      else pass_cnt++;
    end
    bus.score_inc = 1'b1;
    bus.score_clr = 1'b1;
    tick();
    bus.score_inc = 1'b0;
    bus.score_clr = 1'b0;
    total++;
    if (bus.gpio_score !== 4'd0)
      $display("FAIL score_clr got %0d exp 0", bus.gpio_score);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      bus.score_inc = 1'b1;
      tick();
      bus.score_inc = 1'b0;
    end
    bus.gpio_move = 2'b01;
    repeat (10) tick();
    total++;
    if (bus.move_up !== 1'b1 || bus.gpio_score !== 4'd5)
      $display("FAIL pre_reset got up=%0b score=%0d exp up=1 score=5",
               bus.move_up, bus.gpio_score);
    else pass_cnt++;
    rst = 1'b1;
    bus.gpio_play = 1'b0;
    tick();
    total++;
    if (bus.move_up !== 1'b0 || bus.move_down !== 1'b0 ||
        bus.play_pulse !== 1'b0 || bus.colour_out !== 3'b000 ||
        bus.gpio_score !== 4'd0)
      $display("FAIL mid_reset got up=%0b dn=%0b pl=%0b col=%0b sc=%0d exp all 0",
               bus.move_up, bus.move_down, bus.play_pulse,
               bus.colour_out, bus.gpio_score);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.play_pulse === 1'b1) pulses++;
      if (k == 5 || k == 6) begin
        total++;
        if (bus.move_up !== (k == 6))
          $display("FAIL rel_up k=%0d got %0b exp %0b",
                   k, bus.move_up, (k == 6));
        else pass_cnt++;
      end
    end
    total++;
    if (pulses !== 0)
      $display("FAIL rel_play got %0d pulses exp 0", pulses);
    else pass_cnt++;
    pulses = 0;
    bus.gpio_play = 1'b1;
    repeat (12) tick();
    bus.gpio_play = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.play_pulse === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1)
      $display("FAIL repress_play got %0d pulses exp 1", pulses);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_move();
    test_play();
    test_colour();
    test_score();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
